// File: rtl/ram_wb_dp_ctrl.sv
// Dual-port Wishbone classic slave for a 1-cycle-read RAM: RMW byte writes, ack 2 cycles after stb, port A wins same-word hazards.
// Stalled requests retry every cycle from IDLE; define RAM_WB_ERR_EN to answer out-of-range addresses with err instead of wrapping.
module ram_wb_dp_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int MEM_SIZE   = 2048,
    parameter int WB_AW      = ADDR_WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    wba_cyc_i,
    input  logic                    wba_stb_i,
    input  logic                    wba_we_i,
    input  logic [DATA_WIDTH/8-1:0] wba_sel_i,
    input  logic [WB_AW-1:0]        wba_adr_i,
    input  logic [DATA_WIDTH-1:0]   wba_dat_i,
    output logic [DATA_WIDTH-1:0]   wba_dat_o,
    output logic                    wba_ack_o,
    output logic                    wba_err_o,
    output logic [ADDR_WIDTH-1:0]   ram_adr_a,
    output logic [DATA_WIDTH-1:0]   ram_d_a,
    output logic                    ram_we_a,
    input  logic [DATA_WIDTH-1:0]   ram_q_a,

    input  logic                    wbb_cyc_i,
    input  logic                    wbb_stb_i,
    input  logic                    wbb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wbb_sel_i,
    input  logic [WB_AW-1:0]        wbb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbb_dat_i,
    output logic [DATA_WIDTH-1:0]   wbb_dat_o,
    output logic                    wbb_ack_o,
    output logic                    wbb_err_o,
    output logic [ADDR_WIDTH-1:0]   ram_adr_b,
    output logic [DATA_WIDTH-1:0]   ram_d_b,
    output logic                    ram_we_b,
    input  logic [DATA_WIDTH-1:0]   ram_q_b
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LP_MEM_WORDS = (ADDR_WIDTH + 1)'(MEM_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

    state_t                r_state [2];
    logic [DATA_WIDTH-1:0] r_dat   [2];
    logic [1:0]            r_ack;
    logic [1:0]            r_err;

    logic [1:0]            w_cyc, w_stb, w_we, w_req, w_rdwr, w_oob, w_bad, w_go;
    logic [SW-1:0]         w_sel  [2];
    logic [WB_AW-1:0]      w_adr  [2];
    logic [DATA_WIDTH-1:0] w_dat  [2];
    logic [DATA_WIDTH-1:0] w_q    [2];
    logic [DATA_WIDTH-1:0] w_d    [2];
    logic [ADDR_WIDTH-1:0] w_word [2];
    logic                  w_same, w_go_a, w_go_b, w_blk_a, w_blk_b;
    logic                  w_unused;

    assign w_cyc    = {wbb_cyc_i, wba_cyc_i};
    assign w_stb    = {wbb_stb_i, wba_stb_i};
    assign w_we     = {wbb_we_i,  wba_we_i};
    assign w_sel[0] = wba_sel_i;
    assign w_sel[1] = wbb_sel_i;
    assign w_adr[0] = wba_adr_i;
    assign w_adr[1] = wbb_adr_i;
    assign w_dat[0] = wba_dat_i;
    assign w_dat[1] = wbb_dat_i;
    assign w_q[0]   = ram_q_a;
    assign w_q[1]   = ram_q_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_word[p] = w_adr[p][ADDR_WIDTH+1:2];
            w_req[p]  = w_cyc[p] & w_stb[p];
            w_oob[p]  = (|({1'b0, w_adr[p]} >> (ADDR_WIDTH + 2))) |
                        ({1'b0, w_word[p]} >= LP_MEM_WORDS);
            w_rdwr[p] = (r_state[p] == S_RD) & w_cyc[p] & w_we[p];
            // Merge new bytes over the word the RAM returned this cycle.
            w_d[p]    = w_q[p];
            for (int i = 0; i < SW; i++) begin
                if (w_sel[p][i]) begin
                    w_d[p][8*i +: 8] = w_dat[p][8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_WB_ERR_EN
    assign w_bad    = w_oob;
    assign w_unused = w_go_b;
`else
    assign w_bad    = 2'b00;
    assign w_unused = ^{w_go_b, w_oob};
`endif

    // Port B yields to any same-word pairing that involves a write; A yields only to a B write already underway.
    assign w_same  = (w_word[0] == w_word[1]);
    assign w_blk_a = w_same & w_rdwr[1];
    assign w_go_a  = (r_state[0] == S_IDLE) & w_req[0] & ~w_bad[0] & ~w_blk_a;
    assign w_blk_b = w_same & ((w_go_a & (w_we[0] | w_we[1])) | w_rdwr[0]);
    assign w_go_b  = (r_state[1] == S_IDLE) & w_req[1] & ~w_bad[1] & ~w_blk_b;
    assign w_go    = {w_go_b, w_go_a};

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                r_state[p] <= S_IDLE;
                r_ack[p]   <= 1'b0;
                r_err[p]   <= 1'b0;
                r_dat[p]   <= '0;
            end else begin
                r_ack[p] <= 1'b0;
                r_err[p] <= 1'b0;
                case (r_state[p])
                    S_IDLE: begin
                        if (w_req[p] && w_bad[p]) begin
                            r_err[p]   <= 1'b1;
                            r_state[p] <= S_ACK;
                        end else if (w_go[p]) begin
                            r_state[p] <= S_RD;
                        end
                    end
                    S_RD: begin
                        if (!w_cyc[p]) begin
                            r_state[p] <= S_IDLE;
                        end else begin
                            if (!w_we[p]) begin
                                r_dat[p] <= w_q[p];
                            end
                            r_ack[p]   <= 1'b1;
                            r_state[p] <= S_ACK;
                        end
                    end
                    S_ACK:   r_state[p] <= S_IDLE;
                    default: r_state[p] <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_adr_a = w_word[0];
    assign ram_adr_b = w_word[1];
    assign ram_d_a   = w_d[0];
    assign ram_d_b   = w_d[1];
    // A reset landing on the RD cycle must also suppress that cycle's write.
    assign ram_we_a  = w_rdwr[0] & ~rst;
    assign ram_we_b  = w_rdwr[1] & ~rst;

    assign wba_dat_o = r_dat[0];
    assign wbb_dat_o = r_dat[1];
    assign wba_ack_o = r_ack[0];
    assign wbb_ack_o = r_ack[1];
    assign wba_err_o = r_err[0];
    assign wbb_err_o = r_err[1];

endmodule

// File: tb/tb_ram_wb_dp_ctrl.sv
// Scoreboard bench for ram_wb_dp_ctrl with a behavioural two-port RAM and a word-level shadow memory model.
module tb_ram_wb_dp_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int MS  = 2048;
    localparam int WAW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            wba_cyc_i = 0, wba_stb_i = 0, wba_we_i = 0;
    logic [3:0]      wba_sel_i = 0;
    logic [WAW-1:0]  wba_adr_i = 0;
    logic [DW-1:0]   wba_dat_i = 0;
    logic [DW-1:0]   wba_dat_o;
    logic            wba_ack_o, wba_err_o;
    logic [AW-1:0]   ram_adr_a;
    logic [DW-1:0]   ram_d_a, ram_q_a;
    logic            ram_we_a;

    logic            wbb_cyc_i = 0, wbb_stb_i = 0, wbb_we_i = 0;
    logic [3:0]      wbb_sel_i = 0;
    logic [WAW-1:0]  wbb_adr_i = 0;
    logic [DW-1:0]   wbb_dat_i = 0;
    logic [DW-1:0]   wbb_dat_o;
    logic            wbb_ack_o, wbb_err_o;
    logic [AW-1:0]   ram_adr_b;
    logic [DW-1:0]   ram_d_b, ram_q_b;
    logic            ram_we_b;

    int checks = 0;
    int errors = 0;
    int n_we_a = 0;
    int n_we_b = 0;

    typedef struct {
        int          kind;   // 0 write ack, 1 read ack, 2 error
        logic [31:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    logic [31:0] ram    [0:MS-1];
    logic [31:0] shadow [0:MS-1];

    ram_wb_dp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .WB_AW(WAW)) dut (
        .clk(clk), .rst(rst),
        .wba_cyc_i(wba_cyc_i), .wba_stb_i(wba_stb_i), .wba_we_i(wba_we_i), .wba_sel_i(wba_sel_i),
        .wba_adr_i(wba_adr_i), .wba_dat_i(wba_dat_i), .wba_dat_o(wba_dat_o), .wba_ack_o(wba_ack_o),
        .wba_err_o(wba_err_o), .ram_adr_a(ram_adr_a), .ram_d_a(ram_d_a), .ram_we_a(ram_we_a),
        .ram_q_a(ram_q_a),
        .wbb_cyc_i(wbb_cyc_i), .wbb_stb_i(wbb_stb_i), .wbb_we_i(wbb_we_i), .wbb_sel_i(wbb_sel_i),
        .wbb_adr_i(wbb_adr_i), .wbb_dat_i(wbb_dat_i), .wbb_dat_o(wbb_dat_o), .wbb_ack_o(wbb_ack_o),
        .wbb_err_o(wbb_err_o), .ram_adr_b(ram_adr_b), .ram_d_b(ram_d_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b)
    );

    // Two-port synchronous RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_adr_a] <= ram_d_a;
        if (ram_we_b) ram[ram_adr_b] <= ram_d_b;
        ram_q_a <= ram[ram_adr_a];
        ram_q_b <= ram[ram_adr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic mon(input bit pb, input logic ack, input logic err, input logic [31:0] dat);
        exp_t e;
        checks++;
        if ((pb ? qb.size() : qa.size()) == 0) begin
            errors++;
            $display("FAIL port%s_unexpected: ack=%0b err=%0b, expected no response", pb ? "B" : "A", ack, err);
            return;
        end
        if (pb) e = qb.pop_front();
        else    e = qa.pop_front();
        if (e.kind == 2) begin
            if (!(err && !ack)) begin
                errors++;
                $display("FAIL port%s_err: ack=%0b err=%0b, expected ack=0 err=1", pb ? "B" : "A", ack, err);
            end
        end else if (!ack || err || (e.kind == 1 && dat !== e.data)) begin
            errors++;
            $display("FAIL port%s_resp: ack=%0b err=%0b dat=0x%08h, expected ack=1 err=0 dat=0x%08h (kind %0d)",
                     pb ? "B" : "A", ack, err, dat, e.data, e.kind);
        end
    endtask

    // Monitor: decoupled from stimulus, pops one expectation per response.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we_a) n_we_a++;
            if (ram_we_b) n_we_b++;
            if (ram_we_a && ram_we_b) begin
                checks++;
                if (ram_adr_a == ram_adr_b) begin
                    errors++;
                    $display("FAIL dual_write: both ports write word 0x%03h, expected never", ram_adr_a);
                end
            end
            if (wba_ack_o || wba_err_o) mon(1'b0, wba_ack_o, wba_err_o, wba_dat_o);
            if (wbb_ack_o || wbb_err_o) mon(1'b1, wbb_ack_o, wbb_err_o, wbb_dat_o);
        end
    end

    // Reference model: transactions take effect in order, port A before port B.
    function automatic void issue(input bit pb, input bit we, input logic [3:0] sel,
                                  input logic [15:0] adr, input logic [31:0] dat);
        exp_t e;
        int   w;
        w = int'(adr) / 4;
`ifdef RAM_WB_ERR_EN
        if (w >= MS) begin
            e.kind = 2;
            e.data = 0;
            if (pb) qb.push_back(e); else qa.push_back(e);
            return;
        end
`endif
        w = w % MS;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) shadow[w][8*i +: 8] = dat[8*i +: 8];
        end
        e.kind = we ? 0 : 1;
        e.data = shadow[w];
        if (pb) qb.push_back(e); else qa.push_back(e);
    endfunction

    task automatic xfer(input bit pb, input int dly, input bit we, input logic [3:0] sel,
                        input logic [15:0] adr, input logic [31:0] dat, output int lat);
        lat = -1;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        if (pb) begin
            wbb_cyc_i = 1; wbb_stb_i = 1; wbb_we_i = we; wbb_sel_i = sel; wbb_adr_i = adr; wbb_dat_i = dat;
        end else begin
            wba_cyc_i = 1; wba_stb_i = 1; wba_we_i = we; wba_sel_i = sel; wba_adr_i = adr; wba_dat_i = dat;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pb ? (wbb_ack_o | wbb_err_o) : (wba_ack_o | wba_err_o)) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL port%s_timeout: no response in 40 cycles, expected one", pb ? "B" : "A");
        end
        @(posedge clk);
        #1;
        if (pb) begin wbb_cyc_i = 0; wbb_stb_i = 0; end
        else    begin wba_cyc_i = 0; wba_stb_i = 0; end
    endtask

    task automatic single(input bit pb, input bit we, input logic [3:0] sel,
                          input logic [15:0] adr, input logic [31:0] dat, output int lat);
        issue(pb, we, sel, adr, dat);
        xfer(pb, 0, we, sel, adr, dat, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, we0, we1;
        logic [31:0] dsave;
        for (int i = 0; i < MS; i++) shadow[i] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack_a", {31'b0, wba_ack_o}, 0);
        chk("rst_err_a", {31'b0, wba_err_o}, 0);
        chk("rst_dat_a", wba_dat_o, 0);
        chk("rst_we_a",  {31'b0, ram_we_a}, 0);
        chk("rst_ack_b", {31'b0, wbb_ack_o}, 0);
        chk("rst_err_b", {31'b0, wbb_err_o}, 0);
        chk("rst_dat_b", wbb_dat_o, 0);
        chk("rst_we_b",  {31'b0, ram_we_b}, 0);
        @(posedge clk);
        #1 rst = 0;

        for (int w = 0; w < 32; w++) single(0, 1, 4'hF, 16'(w * 4), 32'h0, la);

        // Full write then read on A.
        we0 = n_we_a;
        single(0, 1, 4'hF, 16'h0010, 32'hDEADBEEF, la);
        chk("t1_wr_latency", la, 2);
        chk("t1_we_cycles", n_we_a - we0, 1);
        single(0, 0, 4'hF, 16'h0010, 32'h0, la);
        chk("t1_rd_latency", la, 2);
        chk("t1_rd_data", wba_dat_o, 32'hDEADBEEF);

        // Byte-select RMW on B.
        single(0, 1, 4'hF, 16'h0020, 32'h11223344, la);
        single(1, 1, 4'h5, 16'h0020, 32'hAABBCCDD, lb);
        chk("t2_b_latency", lb, 2);
        single(1, 0, 4'hF, 16'h0020, 32'h0, lb);
        chk("t2_rd_data", wbb_dat_o, 32'h11BB33DD);

        // Simultaneous writes to one word.
        issue(0, 1, 4'hF, 16'h0040, 32'h1);
        issue(1, 1, 4'hF, 16'h0040, 32'h2);
        fork
            xfer(0, 0, 1, 4'hF, 16'h0040, 32'h1, la);
            xfer(1, 0, 1, 4'hF, 16'h0040, 32'h2, lb);
        join
        chk("t3_a_latency", la, 2);
        chk("t3_b_after_a", (lb > la) ? 32'd1 : 32'd0, 1);
        single(0, 0, 4'hF, 16'h0040, 32'h0, la);
        chk("t3_final", wba_dat_o, 32'h2);

        // Parallel reads of different words.
        single(0, 1, 4'hF, 16'h0000, 32'hCAFE0000, la);
        single(1, 1, 4'hF, 16'h0004, 32'h0000F00D, lb);
        issue(0, 0, 4'hF, 16'h0000, 32'h0);
        issue(1, 0, 4'hF, 16'h0004, 32'h0);
        fork
            xfer(0, 0, 0, 4'hF, 16'h0000, 32'h0, la);
            xfer(1, 0, 0, 4'hF, 16'h0004, 32'h0, lb);
        join
        chk("t4_a_latency", la, 2);
        chk("t4_b_latency", lb, 2);
        chk("t4_a_data", wba_dat_o, 32'hCAFE0000);
        chk("t4_b_data", wbb_dat_o, 32'h0000F00D);

        // Reset while A sits in RD with a write.
        we0 = n_we_a;
        @(posedge clk);
        #1;
        wba_cyc_i = 1; wba_stb_i = 1; wba_we_i = 1; wba_sel_i = 4'hF; wba_adr_i = 16'h0008; wba_dat_i = 32'h55;
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("t5_we_gated", {31'b0, ram_we_a}, 0);
        @(posedge clk);
        #1;
        rst = 0; wba_cyc_i = 0; wba_stb_i = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_ack", {31'b0, wba_ack_o}, 0);
        end
        chk("t5_dat_reset", wba_dat_o, 0);
        chk("t5_no_write", n_we_a - we0, 0);
        single(0, 0, 4'hF, 16'h0008, 32'h0, la);
        chk("t5_readback", wba_dat_o, 32'h0);

        // Address above the RAM.
        we0 = n_we_a;
        dsave = wba_dat_o;
        single(0, 1, 4'hF, 16'h2000, 32'h77, la);
`ifdef RAM_WB_ERR_EN
        chk("t6_no_write", n_we_a - we0, 0);
        chk("t6_dat_kept", wba_dat_o, dsave);
`else
        chk("t6_wrap_write", n_we_a - we0, 1);
        chk("t6_latency", la, 2);
        single(0, 0, 4'hF, 16'h0000, 32'h0, la);
        chk("t6_wrap_data", wba_dat_o, 32'h77);
`endif

        // Random mix with B optionally one cycle behind.
        we1 = 0;
        for (int r = 0; r < 200; r++) begin
            bit          wa, wb, bon;
            logic [3:0]  sa, sb;
            logic [15:0] aa, ab;
            logic [31:0] da, db;
            int          dly;
            wa  = 1'($urandom_range(0, 1));
            wb  = 1'($urandom_range(0, 1));
            sa  = 4'($urandom_range(0, 15));
            sb  = 4'($urandom_range(0, 15));
            aa  = 16'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
            ab  = 16'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
            da  = $urandom;
            db  = $urandom;
            bon = ($urandom_range(0, 3) != 0);
            dly = $urandom_range(0, 1);
            issue(0, wa, sa, aa, da);
            if (bon) begin
                issue(1, wb, sb, ab, db);
                fork
                    xfer(0, 0,   wa, sa, aa, da, la);
                    xfer(1, dly, wb, sb, ab, db, lb);
                join
                if (dly == 0 && la != 2) we1++;
            end else begin
                xfer(0, 0, wa, sa, aa, da, la);
                if (la != 2) we1++;
            end
        end
        chk("rand_a_latency_not_2", we1, 0);

        repeat (5) @(negedge clk);
        chk("drain_qa", qa.size(), 0);
        chk("drain_qb", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
